// File: rtl/puf_pkg.sv
// puf_pkg: shared types and constants for the ring-oscillator PUF challenge reader.
//   state_t        FSM state encoding (also exposed on the debug port fsm_state)
//   SEL_W / LFSR_W select and LFSR widths
//   LFSR_TAP_*     feedback taps of x^10 + x^7 + 1
//   ZERO_SEED_SUB  substitute for an all-zero seed, which would lock the LFSR
//   lfsr_step      one left shift of the Fibonacci LFSR
package puf_pkg;

    localparam int SEL_W      = 5;
    localparam int LFSR_W     = 10;
    localparam int LFSR_TAP_HI = 9;
    localparam int LFSR_TAP_LO = 6;
    localparam logic [LFSR_W-1:0] ZERO_SEED_SUB = 10'h001;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_CLEAR   = 3'd1,
        ST_MEASURE = 3'd2,
        ST_SETTLE  = 3'd3,
        ST_COMPARE = 3'd4,
        ST_DONE    = 3'd5
    } state_t;

    function automatic logic [LFSR_W-1:0] lfsr_step(input logic [LFSR_W-1:0] v);
        return {v[LFSR_W-2:0], v[LFSR_TAP_HI] ^ v[LFSR_TAP_LO]};
    endfunction

endpackage

// File: rtl/puf_lfsr10.sv
// puf_lfsr10: 10-bit challenge LFSR with registered oscillator selects.
//   clk    system clock
//   rst    synchronous active-high reset (lfsr = 10'h001, selects = 0)
//   load   load seed (zero seed replaced by 10'h001)
//   step   advance LFSR one step
//   seed   seed value
//   sel_a  bank A select, lfsr[4:0]
//   sel_b  bank B select, lfsr[9:5], bit 0 flipped if it collides with sel_a
//   value  current LFSR state
// The selects are derived from the next LFSR value and registered on the same
// edge, so they change exactly when the LFSR does and hold in between.
import puf_pkg::*;

module puf_lfsr10 (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic              step,
    input  logic [LFSR_W-1:0] seed,
    output logic [SEL_W-1:0]  sel_a,
    output logic [SEL_W-1:0]  sel_b,
    output logic [LFSR_W-1:0] value
);

    logic [LFSR_W-1:0] lfsr_d;
    logic [SEL_W-1:0]  sel_a_d;
    logic [SEL_W-1:0]  sel_b_d;

    always_comb begin
        lfsr_d = value;
        if (load) begin
            lfsr_d = (seed == '0) ? ZERO_SEED_SUB : seed;
        end else if (step) begin
            lfsr_d = lfsr_step(value);
        end
        sel_a_d = lfsr_d[SEL_W-1:0];
        sel_b_d = lfsr_d[LFSR_W-1:SEL_W];
        // Both banks on the same oscillator index would measure nothing useful.
        if (sel_b_d == sel_a_d) begin
            sel_b_d = sel_b_d ^ 5'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            value <= ZERO_SEED_SUB;
            sel_a <= '0;
            sel_b <= '0;
        end else if (load || step) begin
            value <= lfsr_d;
            sel_a <= sel_a_d;
            sel_b <= sel_b_d;
        end
    end

endmodule

// File: rtl/puf_challenge_reader.sv
// puf_challenge_reader: challenge sequencer and response reader for the RO PUF.
//   clk        system clock
//   rst_n      synchronous reset, active HIGH despite the name (1 = reset)
//   start      begin a response (sampled in IDLE only)
//   seed       LFSR seed latched on start
//   busy       high from the cycle after start until DONE is left
//   sel_a/b    oscillator selects for banks A/B
//   osc_en     oscillator enable, high during MEASURE
//   cnt_clr    counter clear pulse, high during CLEAR
//   cnt_a/b    bank counts, stable in SETTLE/COMPARE
//   resp       response word, first challenge bit in the MSB
//   resp_valid/resp_ready  handshake: the word transfers on a cycle where both
//              are high; resp_valid stays high and resp stable until then
//   tie        sticky, some compare in this response saw cnt_a == cnt_b
//   fsm_state  current FSM state (debug)
// Optional macro PUF_MAJORITY_EN: each challenge is measured three times and
// the response bit is the 2-of-3 majority of cnt_a > cnt_b.
import puf_pkg::*;

module puf_challenge_reader #(
    parameter int RESP_BITS  = 16,
    parameter int WIN_CYCLES = 1024,
    parameter int CNT_W      = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [9:0]           seed,
    output logic                 busy,
    output logic [4:0]           sel_a,
    output logic [4:0]           sel_b,
    output logic                 osc_en,
    output logic                 cnt_clr,
    input  logic [CNT_W-1:0]     cnt_a,
    input  logic [CNT_W-1:0]     cnt_b,
    output logic [RESP_BITS-1:0] resp,
    output logic                 resp_valid,
    input  logic                 resp_ready,
    output logic                 tie,
    output logic [2:0]           fsm_state
);

    localparam int TW = $clog2(WIN_CYCLES + 2);
    localparam int BW = $clog2(RESP_BITS + 1);

    state_t           state;
    logic [TW-1:0]    timer;
    logic [BW-1:0]    bit_cnt;
    logic             gt;
    logic             eq;
    logic             bit_val;
    logic             last_bit;
    logic             lfsr_load;
    logic             lfsr_step_en;
    logic [RESP_BITS-1:0] resp_next;
    logic [LFSR_W-1:0]    lfsr_value;
`ifdef PUF_MAJORITY_EN
    logic [1:0]       run_cnt;
    logic [1:0]       vote;
`endif

    assign fsm_state    = state;
    assign gt           = cnt_a > cnt_b;
    assign eq           = cnt_a == cnt_b;
    assign last_bit     = bit_cnt == BW'(RESP_BITS - 1);
    assign lfsr_load    = (state == ST_IDLE) && start;
    assign lfsr_step_en = (state == ST_COMPARE) && !last_bit;

`ifdef PUF_MAJORITY_EN
    // Third run is judged live in COMPARE; the first two are already in vote.
    assign bit_val = ({1'b0, vote} + {2'b00, gt}) >= 3'd2;
`else
    assign bit_val = gt;
`endif

    always_comb begin
        resp_next    = resp << 1;
        resp_next[0] = bit_val;
    end

    puf_lfsr10 u_lfsr (
        .clk   (clk),
        .rst   (rst_n),
        .load  (lfsr_load),
        .step  (lfsr_step_en),
        .seed  (seed),
        .sel_a (sel_a),
        .sel_b (sel_b),
        .value (lfsr_value)
    );

    always_ff @(posedge clk) begin
        if (rst_n) begin
            state      <= ST_IDLE;
            timer      <= '0;
            bit_cnt    <= '0;
            busy       <= 1'b0;
            osc_en     <= 1'b0;
            cnt_clr    <= 1'b0;
            resp       <= '0;
            resp_valid <= 1'b0;
            tie        <= 1'b0;
`ifdef PUF_MAJORITY_EN
            run_cnt    <= '0;
            vote       <= '0;
`endif
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        state   <= ST_CLEAR;
                        busy    <= 1'b1;
                        cnt_clr <= 1'b1;
                        resp    <= '0;
                        tie     <= 1'b0;
                        bit_cnt <= '0;
`ifdef PUF_MAJORITY_EN
                        run_cnt <= '0;
                        vote    <= '0;
`endif
                    end
                end
                ST_CLEAR: begin
                    cnt_clr <= 1'b0;
                    osc_en  <= 1'b1;
                    timer   <= '0;
                    state   <= ST_MEASURE;
                end
                ST_MEASURE: begin
                    if (timer == TW'(WIN_CYCLES - 1)) begin
                        osc_en <= 1'b0;
                        timer  <= '0;
                        state  <= ST_SETTLE;
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                ST_SETTLE: begin
                    if (timer == TW'(1)) begin
`ifdef PUF_MAJORITY_EN
                        if (run_cnt == 2'd2) begin
                            state <= ST_COMPARE;
                        end else begin
                            // Record this run and re-measure the same pair.
                            run_cnt <= run_cnt + 1'b1;
                            vote    <= vote + {1'b0, gt};
                            tie     <= tie | eq;
                            cnt_clr <= 1'b1;
                            state   <= ST_CLEAR;
                        end
`else
                        state <= ST_COMPARE;
`endif
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                ST_COMPARE: begin
                    resp <= resp_next;
                    tie  <= tie | eq;
                    if (last_bit) begin
                        resp_valid <= 1'b1;
                        state      <= ST_DONE;
                    end else begin
                        bit_cnt <= bit_cnt + 1'b1;
                        cnt_clr <= 1'b1;
                        state   <= ST_CLEAR;
`ifdef PUF_MAJORITY_EN
                        run_cnt <= '0;
                        vote    <= '0;
`endif
                    end
                end
                ST_DONE: begin
                    if (resp_ready) begin
                        resp_valid <= 1'b0;
                        busy       <= 1'b0;
                        state      <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // The LFSR state itself is only consumed through the selects.
    logic unused_ok;
    assign unused_ok = ^lfsr_value;

endmodule

// File: tb/tb_puf_challenge_reader.sv
module tb_puf_challenge_reader;
    import puf_pkg::*;

    localparam int WIN = 8;
    localparam int RB  = 16;
    localparam int CW  = 16;
`ifdef PUF_MAJORITY_EN
    localparam int RUNS = 3;
    localparam int P    = 3 * (WIN + 3) + 1;
`else
    localparam int RUNS = 1;
    localparam int P    = WIN + 4;
`endif
    localparam int VALID_CYC = RB * P + 1;
    localparam int LIMIT     = 2000;

    logic          clk;
    logic          rst_n;
    logic          start;
    logic [9:0]    seed;
    logic          busy;
    logic [4:0]    sel_a;
    logic [4:0]    sel_b;
    logic          osc_en;
    logic          cnt_clr;
    logic [CW-1:0] cnt_a;
    logic [CW-1:0] cnt_b;
    logic [RB-1:0] resp;
    logic          resp_valid;
    logic          resp_ready;
    logic          tie;
    logic [2:0]    fsm_state;

    int n_cmp;
    int n_fail;

    // Counter model: mode 0 constant, mode 1 per-challenge pattern bit,
    // mode 2 per-run a>b, a<b, a>b.
    int            pat_mode;
    logic [15:0]   pat;
    logic [CW-1:0] const_a;
    logic [CW-1:0] const_b;
    int            clr_n;
    int            clr_base;
    logic [4:0]    sel_a_p1;
    logic [4:0]    sel_b_p1;

    puf_challenge_reader #(
        .RESP_BITS  (RB),
        .WIN_CYCLES (WIN),
        .CNT_W      (CW)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .seed       (seed),
        .busy       (busy),
        .sel_a      (sel_a),
        .sel_b      (sel_b),
        .osc_en     (osc_en),
        .cnt_clr    (cnt_clr),
        .cnt_a      (cnt_a),
        .cnt_b      (cnt_b),
        .resp       (resp),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .tie        (tie),
        .fsm_state  (fsm_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        int r;
        int b;
        logic g;
        if (pat_mode == 0) begin
            cnt_a = const_a;
            cnt_b = const_b;
        end else if (cnt_clr) begin
            r = (clr_n - clr_base) % RUNS;
            b = (clr_n - clr_base) / RUNS;
            if (pat_mode == 1) g = (b < 16) ? pat[15 - b] : 1'b0;
            else               g = (r != 1);
            cnt_a = g ? 16'd200 : 16'd100;
            cnt_b = g ? 16'd100 : 16'd200;
        end
        if (cnt_clr) clr_n = clr_n + 1;
    end

    // Pulse start; returns in cycle 1 (CLEAR).
    task automatic start_resp(input logic [9:0] s);
        seed  = s;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    // Wait for resp_valid, counting cycles from the given cycle number.
    task automatic wait_valid(input int from, output int cyc, output bit overlap);
        cyc = from;
        overlap = 1'b0;
        while (!resp_valid && cyc < LIMIT) begin
            if (osc_en && cnt_clr) overlap = 1'b1;
            @(posedge clk); #1;
            cyc++;
            if (cyc == P + 1) begin
                sel_a_p1 = sel_a;
                sel_b_p1 = sel_b;
            end
        end
    endtask

    task automatic accept();
        resp_ready = 1'b1;
        @(posedge clk); #1;
        resp_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
        n_cmp++; if (osc_en !== 1'b0) begin n_fail++; $display("FAIL reset_osc_en: got %b want 0", osc_en); end
        n_cmp++; if (cnt_clr !== 1'b0) begin n_fail++; $display("FAIL reset_cnt_clr: got %b want 0", cnt_clr); end
        n_cmp++; if (resp !== 16'h0000) begin n_fail++; $display("FAIL reset_resp: got %h want 0000", resp); end
        n_cmp++; if (resp_valid !== 1'b0) begin n_fail++; $display("FAIL reset_resp_valid: got %b want 0", resp_valid); end
        n_cmp++; if (tie !== 1'b0) begin n_fail++; $display("FAIL reset_tie: got %b want 0", tie); end
        n_cmp++; if (sel_a !== 5'd0 || sel_b !== 5'd0) begin n_fail++; $display("FAIL reset_sel: got %0d/%0d want 0/0", sel_a, sel_b); end
        n_cmp++; if (fsm_state !== ST_IDLE) begin n_fail++; $display("FAIL reset_state: got %0d want %0d", fsm_state, ST_IDLE); end
        rst_n = 1'b0;
    endtask

    task automatic test_all_ones();
        int cyc;
        bit ov;
        pat_mode = 0; const_a = 16'd100; const_b = 16'd50;
        @(posedge clk); #1;
        start_resp(10'h155);
        n_cmp++; if (sel_a !== 5'd21 || sel_b !== 5'd10) begin n_fail++; $display("FAIL ones_first_sel: got %0d/%0d want 21/10", sel_a, sel_b); end
        n_cmp++; if (cnt_clr !== 1'b1 || osc_en !== 1'b0) begin n_fail++; $display("FAIL ones_clear_cycle: got clr=%b en=%b want 1/0", cnt_clr, osc_en); end
        n_cmp++; if (busy !== 1'b1) begin n_fail++; $display("FAIL ones_busy: got %b want 1", busy); end
        @(posedge clk); #1;
        n_cmp++; if (cnt_clr !== 1'b0 || osc_en !== 1'b1) begin n_fail++; $display("FAIL ones_measure_cycle: got clr=%b en=%b want 0/1", cnt_clr, osc_en); end
        wait_valid(2, cyc, ov);
        n_cmp++; if (cyc !== VALID_CYC) begin n_fail++; $display("FAIL ones_valid_cycle: got %0d want %0d", cyc, VALID_CYC); end
        n_cmp++; if (resp !== 16'hFFFF) begin n_fail++; $display("FAIL ones_resp: got %h want ffff", resp); end
        n_cmp++; if (tie !== 1'b0) begin n_fail++; $display("FAIL ones_tie: got %b want 0", tie); end
        n_cmp++; if (ov !== 1'b0) begin n_fail++; $display("FAIL ones_en_clr_overlap: got %b want 0", ov); end
        // LFSR 0x155 steps to 0x2AB: sel_a = 11, sel_b = 21.
        n_cmp++; if (sel_a_p1 !== 5'd11 || sel_b_p1 !== 5'd21) begin n_fail++; $display("FAIL ones_second_sel: got %0d/%0d want 11/21", sel_a_p1, sel_b_p1); end
        accept();
    endtask

    task automatic test_tie();
        int cyc;
        bit ov;
        pat_mode = 0; const_a = 16'd77; const_b = 16'd77;
        @(posedge clk); #1;
        start_resp(10'h2C7);
        wait_valid(1, cyc, ov);
        n_cmp++; if (cyc !== VALID_CYC) begin n_fail++; $display("FAIL tie_valid_cycle: got %0d want %0d", cyc, VALID_CYC); end
        n_cmp++; if (resp !== 16'h0000) begin n_fail++; $display("FAIL tie_resp: got %h want 0000", resp); end
        n_cmp++; if (tie !== 1'b1) begin n_fail++; $display("FAIL tie_flag: got %b want 1", tie); end
        accept();
    endtask

    task automatic test_seeds();
        pat_mode = 0; const_a = 16'd100; const_b = 16'd50;
        @(posedge clk); #1;
        start_resp(10'h000);
        n_cmp++; if (sel_a !== 5'd1 || sel_b !== 5'd0) begin n_fail++; $display("FAIL zero_seed_sel: got %0d/%0d want 1/0", sel_a, sel_b); end
        n_cmp++; if (fsm_state !== ST_CLEAR) begin n_fail++; $display("FAIL zero_seed_state: got %0d want %0d", fsm_state, ST_CLEAR); end
        rst_n = 1'b1; @(posedge clk); #1; rst_n = 1'b0;
        start_resp(10'h021);
        n_cmp++; if (sel_a !== 5'd1 || sel_b !== 5'd0) begin n_fail++; $display("FAIL collision_sel: got %0d/%0d want 1/0", sel_a, sel_b); end
        rst_n = 1'b1; @(posedge clk); #1; rst_n = 1'b0;
    endtask

    task automatic test_reset_mid();
        int cyc;
        bit ov;
        pat_mode = 0; const_a = 16'd50; const_b = 16'd100;
        start_resp(10'h155);
        repeat (4) @(posedge clk);
        #1;
        n_cmp++; if (osc_en !== 1'b1 || fsm_state !== ST_MEASURE) begin n_fail++; $display("FAIL mid_measure: got en=%b st=%0d want 1/%0d", osc_en, fsm_state, ST_MEASURE); end
        rst_n = 1'b1;
        @(posedge clk); #1;
        rst_n = 1'b0;
        n_cmp++; if (osc_en !== 1'b0 || busy !== 1'b0 || resp !== 16'h0) begin n_fail++; $display("FAIL mid_reset_outputs: got en=%b busy=%b resp=%h want 0/0/0000", osc_en, busy, resp); end
        n_cmp++; if (fsm_state !== ST_IDLE) begin n_fail++; $display("FAIL mid_reset_state: got %0d want %0d", fsm_state, ST_IDLE); end
        start_resp(10'h155);
        wait_valid(1, cyc, ov);
        n_cmp++; if (cyc !== VALID_CYC) begin n_fail++; $display("FAIL mid_restart_cycle: got %0d want %0d", cyc, VALID_CYC); end
        n_cmp++; if (resp !== 16'h0000 || tie !== 1'b0) begin n_fail++; $display("FAIL mid_restart_resp: got %h tie=%b want 0000 tie=0", resp, tie); end
        accept();
    endtask

    task automatic test_hold();
        int cyc;
        bit ov;
        int bad;
        pat = 16'hA5C3; clr_base = clr_n; pat_mode = 1;
        @(posedge clk); #1;
        start_resp(10'h0AB);
        wait_valid(1, cyc, ov);
        n_cmp++; if (cyc !== VALID_CYC) begin n_fail++; $display("FAIL hold_valid_cycle: got %0d want %0d", cyc, VALID_CYC); end
        n_cmp++; if (resp !== 16'hA5C3 || tie !== 1'b0) begin n_fail++; $display("FAIL hold_resp: got %h tie=%b want a5c3 tie=0", resp, tie); end
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            start = (i == 5);
            seed  = 10'h3FF;
            @(posedge clk); #1;
            if (resp_valid !== 1'b1 || resp !== 16'hA5C3 || fsm_state !== ST_DONE) bad++;
        end
        start = 1'b0;
        n_cmp++; if (bad !== 0) begin n_fail++; $display("FAIL hold_stable: got %0d unstable cycles want 0", bad); end
        accept();
        n_cmp++; if (fsm_state !== ST_IDLE || resp_valid !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL hold_release: got st=%0d v=%b busy=%b want %0d/0/0", fsm_state, resp_valid, busy, ST_IDLE); end
        repeat (2) @(posedge clk);
        #1;
        n_cmp++; if (fsm_state !== ST_IDLE) begin n_fail++; $display("FAIL hold_no_restart: got %0d want %0d", fsm_state, ST_IDLE); end
        pat_mode = 0;
    endtask

`ifdef PUF_MAJORITY_EN
    task automatic test_majority();
        int cyc;
        bit ov;
        clr_base = clr_n; pat_mode = 2;
        @(posedge clk); #1;
        start_resp(10'h155);
        wait_valid(1, cyc, ov);
        n_cmp++; if (cyc !== 545) begin n_fail++; $display("FAIL maj_valid_cycle: got %0d want 545", cyc); end
        n_cmp++; if (resp !== 16'hFFFF || tie !== 1'b0) begin n_fail++; $display("FAIL maj_resp: got %h tie=%b want ffff tie=0", resp, tie); end
        accept();
        pat_mode = 0;
    endtask
`endif

    initial begin
        n_cmp = 0; n_fail = 0;
        rst_n = 1'b1; start = 1'b0; seed = '0; resp_ready = 1'b0;
        pat_mode = 0; pat = '0; const_a = '0; const_b = '0;
        clr_n = 0; clr_base = 0; sel_a_p1 = '0; sel_b_p1 = '0;
        test_reset();
        test_all_ones();
        test_tie();
        test_seeds();
        test_reset_mid();
        test_hold();
`ifdef PUF_MAJORITY_EN
        test_majority();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
